// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 transmitter.
package dmx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBreak,
        StMab,
        StSlot,
        StIfg
    } dmx_state_t;

    localparam int unsigned DMX_SLOT_BITS = 11;
    localparam int unsigned DMX_MAX_SLOTS = 512;
    // Wide enough to hold slot indices 0..DMX_MAX_SLOTS (start code plus data slots).
    localparam int unsigned DMX_SLOT_W    = $clog2(DMX_MAX_SLOTS + 1);

    function automatic int unsigned dmx_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/dmx_baud_tick.sv
// Bit-period divider: DIV-cycle down-counter, tick on terminal count, synchronous restart.
module dmx_baud_tick #(
    parameter int unsigned DIV = 48
) (
    input  logic CLK12,
    input  logic RESET,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = $clog2(DIV);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            cnt_q <= W'(DIV - 1);
        end else if (restart || (cnt_q == '0)) begin
            cnt_q <= W'(DIV - 1);
        end else begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/dmx_transmitter.sv
// DMX512 frame transmitter: break, MAB, start code and SLOTS data slots fetched from slot memory.
// Define DMX_FRAME_CNT_EN to build the completed-frame counter driving frame_count.
module dmx_transmitter
    import dmx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 250_000,
    parameter int unsigned SLOTS      = 512,
    parameter int unsigned BREAK_BITS = 22,
    parameter int unsigned MAB_BITS   = 2,
    parameter int unsigned IFG_BITS   = 4
) (
    input  logic        CLK12,
    input  logic        RESET,
    input  logic        enable,
    input  logic [7:0]  start_code,
    output logic        slot_rd,
    output logic [8:0]  slot_addr,
    input  logic [7:0]  slot_data,
    output logic        dmx_data,
    output logic        busy,
    output logic        frame_start,
    output logic        frame_done,
    output logic        sync,
    output logic [15:0] frame_count
);

    localparam int unsigned DIV      = dmx_div(CLK_HZ, BAUD);
    localparam int unsigned LAST_BIT = DMX_SLOT_BITS - 1;

    dmx_state_t            state_q, state_d;
    logic [7:0]            bit_q, bit_d;
    logic [DMX_SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]            start_q, cur_q, cur_d, next_q;
    logic                  cap_q;
    logic                  tick, restart, begin_frame;
    logic                  line_d, rd_d;

    dmx_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .CLK12  (CLK12),
        .RESET  (RESET),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            bit_q       <= '0;
            slot_q      <= '0;
            start_q     <= '0;
            cur_q       <= '0;
            next_q      <= '0;
            cap_q       <= 1'b0;
            dmx_data    <= 1'b1;
            slot_rd     <= 1'b0;
            slot_addr   <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            cur_q       <= cur_d;
            dmx_data    <= line_d;
            slot_rd     <= rd_d;
            frame_start <= begin_frame;
            cap_q       <= slot_rd;
            if (rd_d) begin
                slot_addr <= slot_q[8:0];
            end
            // Memory data is valid the cycle after the read strobe.
            if (cap_q) begin
                next_q <= slot_data;
            end
            if (begin_frame) begin
                start_q <= start_code;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        cur_d       = cur_q;
        begin_frame = 1'b0;
        restart     = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    begin_frame = 1'b1;
                    restart     = 1'b1;
                end
            end
            StBreak: begin
                if (tick) begin
                    if (bit_q == 8'(BREAK_BITS - 1)) begin
                        state_d = StMab;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            StMab: begin
                if (tick) begin
                    if (bit_q == 8'(MAB_BITS - 1)) begin
                        state_d = StSlot;
                        bit_d   = '0;
                        slot_d  = '0;
                        cur_d   = start_q;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            StSlot: begin
                if (tick) begin
                    if (bit_q == 8'(LAST_BIT)) begin
                        bit_d = '0;
                        if (slot_q == DMX_SLOT_W'(SLOTS)) begin
                            frame_done = 1'b1;
                            if (IFG_BITS == 0) begin
                                if (enable) begin
                                    begin_frame = 1'b1;
                                end else begin
                                    state_d = StIdle;
                                end
                            end else begin
                                state_d = StIfg;
                            end
                        end else begin
                            slot_d = slot_q + DMX_SLOT_W'(1);
                            cur_d  = next_q;
                        end
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            StIfg: begin
                if (tick) begin
                    if (bit_q == 8'(IFG_BITS - 1)) begin
                        bit_d = '0;
                        if (enable) begin
                            begin_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (begin_frame) begin
            state_d = StBreak;
            bit_d   = '0;
        end
    end

    // Line level for the bit about to start; registered so edges align with terminal count.
    always_comb begin
        line_d = 1'b1;
        if (state_d == StBreak) begin
            line_d = 1'b0;
        end else if (state_d == StSlot) begin
            if (bit_d == 8'd0) begin
                line_d = 1'b0;
            end else if (bit_d <= 8'd8) begin
                line_d = cur_d[3'(bit_d - 8'd1)];
            end
        end
        rd_d = (state_q == StSlot) && tick && (bit_q == 8'd8) && (slot_q < DMX_SLOT_W'(SLOTS));
    end

    assign busy = (state_q != StIdle);
    assign sync = (state_q == StBreak);

`ifdef DMX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_dmx_transmitter.sv
// Bench for dmx_transmitter: bit-level frame model with scoreboard, plus an IFG=0 back-to-back instance.
module tb_dmx_transmitter;

    localparam int unsigned M_CLK  = 1_250_000;
    localparam int unsigned M_BAUD = 250_000;
    localparam int unsigned DIV    = M_CLK / M_BAUD;
    localparam int unsigned SLOTS  = 8;
    localparam int unsigned BRK    = 22;
    localparam int unsigned MAB    = 2;
    localparam int unsigned IFG    = 4;
    localparam int unsigned TOTAL  = BRK + MAB + 11 * (SLOTS + 1) + IFG;
    localparam int unsigned DSTART = (BRK + MAB) * DIV;
    localparam int unsigned DEND   = (BRK + MAB + 11 * (SLOTS + 1)) * DIV;

    logic        CLK12 = 1'b0;
    logic        RESET;
    logic        enable;
    logic [7:0]  start_code;
    logic        slot_rd;
    logic [8:0]  slot_addr;
    logic [7:0]  slot_data;
    logic        dmx_data, busy, frame_start, frame_done, sync;
    logic [15:0] frame_count;
    logic [7:0]  mem [0:511];

    logic        rst_b, en_b, rd_b, dmx_b, busy_b, fs_b, fd_b, sync_b;
    logic [8:0]  addr_b;
    logic [7:0]  data_b;
    logic [15:0] count_b;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    bit          seq[$];
    bit          mon_active = 1'b0;
    int          pos;
    int          frames_done = 0;
    bit          bit_bad;
    string       bit_msg;
    bit          b_started = 1'b0;
    bit          b_done = 1'b0;
    bit          fd_b_prev = 1'b0;
    int          b_rd_cnt = 0;
    int          b_frames = 0;

    always #5 CLK12 = ~CLK12;

    dmx_transmitter #(
        .CLK_HZ    (M_CLK),
        .BAUD      (M_BAUD),
        .SLOTS     (SLOTS),
        .BREAK_BITS(BRK),
        .MAB_BITS  (MAB),
        .IFG_BITS  (IFG)
    ) dut (
        .CLK12      (CLK12),
        .RESET      (RESET),
        .enable     (enable),
        .start_code (start_code),
        .slot_rd    (slot_rd),
        .slot_addr  (slot_addr),
        .slot_data  (slot_data),
        .dmx_data   (dmx_data),
        .busy       (busy),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .sync       (sync),
        .frame_count(frame_count)
    );

    dmx_transmitter #(
        .CLK_HZ    (1_000_000),
        .BAUD      (250_000),
        .SLOTS     (4),
        .BREAK_BITS(22),
        .MAB_BITS  (2),
        .IFG_BITS  (0)
    ) dut_b2b (
        .CLK12      (CLK12),
        .RESET      (rst_b),
        .enable     (en_b),
        .start_code (8'h00),
        .slot_rd    (rd_b),
        .slot_addr  (addr_b),
        .slot_data  (data_b),
        .dmx_data   (dmx_b),
        .busy       (busy_b),
        .frame_start(fs_b),
        .frame_done (fd_b),
        .sync       (sync_b),
        .frame_count(count_b)
    );

    assign data_b = 8'hA5;

    // Synchronous-read slot memory; garbage on the data bus whenever no read was issued.
    always @(posedge CLK12) begin
        if (slot_rd) slot_data <= mem[slot_addr];
        else         slot_data <= 8'($urandom);
    end

    function automatic void check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endfunction

    function automatic logic [15:0] exp_count();
`ifdef DMX_FRAME_CNT_EN
        return 16'(frames_done);
`else
        return 16'd0;
`endif
    endfunction

    task automatic push_frame(input logic [7:0] sc);
        exp_q.push_back(sc);
        for (int i = 0; i < SLOTS; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic wait_frame_start(input string name);
        int n = 0;
        @(negedge CLK12);
        while (frame_start !== 1'b1 && n < 2000) begin
            @(negedge CLK12);
            n++;
        end
        check(name, frame_start === 1'b1, "got no frame_start, required one within 2000 cycles");
    endtask

    task automatic wait_slot_rd(input string name);
        int n = 0;
        @(negedge CLK12);
        while (slot_rd !== 1'b1 && n < 2000) begin
            @(negedge CLK12);
            n++;
        end
        check(name, slot_rd === 1'b1, "got no slot_rd, required one within 2000 cycles");
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge CLK12);
        while ((busy !== 1'b0 || mon_active) && n < 3000) begin
            @(negedge CLK12);
            n++;
        end
        check(name, busy === 1'b0 && !mon_active,
              $sformatf("got busy=%b, required 0 within 3000 cycles", busy));
    endtask

    // Monitor: at frame_start pops one frame of expected bytes and checks every cycle of it.
    always @(negedge CLK12) begin
        if (RESET) begin
            mon_active  = 1'b0;
            frames_done = 0;
        end else begin
            if (frame_start) begin
                if (mon_active) check("frame_start", 1'b0, $sformatf("got early frame_start at pos %0d", pos));
                if (exp_q.size() < SLOTS + 1) begin
                    check("frame_expected", 1'b0, "got frame_start, required no frame");
                    mon_active = 1'b0;
                end else begin
                    seq.delete();
                    repeat (BRK) seq.push_back(1'b0);
                    repeat (MAB) seq.push_back(1'b1);
                    for (int s = 0; s <= SLOTS; s++) begin
                        logic [7:0] b;
                        b = exp_q.pop_front();
                        seq.push_back(1'b0);
                        for (int i = 0; i < 8; i++) seq.push_back(b[i]);
                        seq.push_back(1'b1);
                        seq.push_back(1'b1);
                    end
                    repeat (IFG) seq.push_back(1'b1);
                    pos        = 0;
                    bit_bad    = 1'b0;
                    mon_active = 1'b1;
                end
            end
            if (mon_active) begin
                int  bitn, rel;
                bit  rd_exp, fd_exp, sy_exp;
                bitn   = pos / DIV;
                sy_exp = (bitn < BRK);
                if (!bit_bad && (dmx_data !== seq[bitn] || busy !== 1'b1 || sync !== sy_exp)) begin
                    bit_bad = 1'b1;
                    bit_msg = $sformatf("bit %0d cycle %0d got line=%b busy=%b sync=%b, required %b 1 %b",
                                        bitn, pos, dmx_data, busy, sync, seq[bitn], sy_exp);
                end
                if (pos % DIV == DIV - 1) begin
                    check("line_bit", !bit_bad, bit_msg);
                    bit_bad = 1'b0;
                end
                fd_exp = (pos == DEND - 1);
                if (fd_exp || frame_done) begin
                    check("frame_done", frame_done === fd_exp,
                          $sformatf("pos %0d got %b, required %b", pos, frame_done, fd_exp));
                end
                if (fd_exp) begin
                    check("frame_count", frame_count === exp_count(),
                          $sformatf("got %0d, required %0d", frame_count, exp_count()));
                    frames_done++;
                end
                rel    = pos - DSTART;
                rd_exp = (pos >= DSTART) && (rel % (11 * DIV) == 9 * DIV) && (rel / (11 * DIV) < SLOTS);
                if (rd_exp || slot_rd) begin
                    check("slot_rd", slot_rd === rd_exp && (!rd_exp || slot_addr == 9'(rel / (11 * DIV))),
                          $sformatf("pos %0d got rd=%b addr=%0d, required rd=%b addr=%0d",
                                    pos, slot_rd, slot_addr, rd_exp, rel / (11 * DIV)));
                end
                pos++;
                if (pos == TOTAL * DIV) mon_active = 1'b0;
            end else if (!frame_start) begin
                check("idle", busy === 1'b0 && dmx_data === 1'b1 && slot_rd === 1'b0 &&
                      frame_done === 1'b0 && sync === 1'b0,
                      $sformatf("got busy=%b line=%b rd=%b done=%b sync=%b, required 0 1 0 0 0",
                                busy, dmx_data, slot_rd, frame_done, sync));
            end
        end
    end

    // Back-to-back instance: gapless frames, four reads 0..3 per frame, busy held.
    always @(negedge CLK12) begin
        if (!rst_b) begin
            if (fs_b) begin
                if (b_started) begin
                    check("b2b_gap", fd_b_prev === 1'b1, "got frame_start without frame_done the cycle before");
                    check("b2b_reads", b_rd_cnt == 4, $sformatf("got %0d reads, required 4", b_rd_cnt));
                    b_frames++;
                end
                b_started = 1'b1;
                b_rd_cnt  = 0;
            end
            if (rd_b) begin
                check("b2b_addr", addr_b == 9'(b_rd_cnt), $sformatf("got %0d, required %0d", addr_b, b_rd_cnt));
                b_rd_cnt++;
            end
            if (b_started && en_b) check("b2b_busy", busy_b === 1'b1, $sformatf("got %b, required 1", busy_b));
            fd_b_prev = fd_b;
        end
    end

    initial begin
        rst_b = 1'b1;
        en_b  = 1'b0;
        repeat (3) @(negedge CLK12);
        rst_b = 1'b0;
        en_b  = 1'b1;
        repeat (3 * 316 + 50) @(negedge CLK12);
        en_b = 1'b0;
        repeat (400) @(negedge CLK12);
        check("b2b_frames", b_frames >= 3, $sformatf("got %0d frames, required >= 3", b_frames));
        b_done = 1'b1;
    end

    initial begin
        logic [7:0] sc;
        RESET      = 1'b0;
        enable     = 1'b0;
        start_code = 8'h00;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        #2 RESET = 1'b1;
        #1;
        check("rst_line", dmx_data === 1'b1, $sformatf("got %b, required 1", dmx_data));
        check("rst_busy", busy === 1'b0, $sformatf("got %b, required 0", busy));
        check("rst_rd", slot_rd === 1'b0, $sformatf("got %b, required 0", slot_rd));
        check("rst_addr", slot_addr === 9'd0, $sformatf("got %0d, required 0", slot_addr));
        check("rst_fs", frame_start === 1'b0, $sformatf("got %b, required 0", frame_start));
        check("rst_fd", frame_done === 1'b0, $sformatf("got %b, required 0", frame_done));
        check("rst_sync", sync === 1'b0, $sformatf("got %b, required 0", sync));
        check("rst_count", frame_count === 16'd0, $sformatf("got %0d, required 0", frame_count));
        repeat (3) @(negedge CLK12);
        RESET = 1'b0;
        repeat (3) @(negedge CLK12);

        // Directed frame: start code 0xCC, memory[0]=0x55; enable dropped during slot 2.
        for (int i = 0; i < SLOTS; i++) mem[i] = 8'(i);
        mem[0]     = 8'h55;
        start_code = 8'hCC;
        push_frame(8'hCC);
        enable = 1'b1;
        @(negedge CLK12);
        check("latency", frame_start === 1'b1 && dmx_data === 1'b0,
              $sformatf("got fs=%b line=%b, required 1 0", frame_start, dmx_data));
        start_code = 8'($urandom);
        repeat (235) @(negedge CLK12);
        enable = 1'b0;
        wait_idle("frame_a_idle");
        repeat (10) @(negedge CLK12);

        // Random back-to-back frames; start code changed after each break start.
        for (int i = 0; i < SLOTS; i++) mem[i] = 8'($urandom);
        sc         = 8'($urandom);
        start_code = sc;
        push_frame(sc);
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_frame_start("rand_frame_start");
            if (f < 2) begin
                sc         = 8'($urandom);
                start_code = sc;
                push_frame(sc);
            end else begin
                start_code = 8'($urandom);
                enable     = 1'b0;
            end
        end
        wait_idle("rand_idle");
        check("queue_empty", exp_q.size() == 0, $sformatf("got %0d bytes left, required 0", exp_q.size()));
        check("count_after", frame_count === exp_count(),
              $sformatf("got %0d, required %0d", frame_count, exp_count()));

        // Reset during a read strobe, then during a low data bit.
        for (int i = 0; i < SLOTS; i++) mem[i] = 8'h00;
        start_code = 8'h00;
        push_frame(8'h00);
        enable = 1'b1;
        wait_frame_start("rst_a_start");
        wait_slot_rd("rst_a_rd");
        RESET = 1'b1;
        #1;
        check("async_rd", slot_rd === 1'b0 && dmx_data === 1'b1 && busy === 1'b0,
              $sformatf("got rd=%b line=%b busy=%b, required 0 1 0", slot_rd, dmx_data, busy));
        exp_q.delete();
        repeat (2) @(negedge CLK12);
        push_frame(8'h00);
        RESET = 1'b0;
        @(negedge CLK12);
        check("restart_a", frame_start === 1'b1 && dmx_data === 1'b0,
              $sformatf("got fs=%b line=%b, required 1 0", frame_start, dmx_data));
        wait_slot_rd("rst_b_rd");
        repeat (3 * DIV + 2) @(negedge CLK12);
        check("data_low", dmx_data === 1'b0, $sformatf("got %b, required 0", dmx_data));
        RESET = 1'b1;
        #1;
        check("async_line", dmx_data === 1'b1 && slot_rd === 1'b0,
              $sformatf("got line=%b rd=%b, required 1 0", dmx_data, slot_rd));
        exp_q.delete();
        repeat (2) @(negedge CLK12);
        push_frame(8'h00);
        RESET = 1'b0;
        @(negedge CLK12);
        check("restart_b", frame_start === 1'b1 && sync === 1'b1,
              $sformatf("got fs=%b sync=%b, required 1 1", frame_start, sync));
        repeat (20) @(negedge CLK12);
        enable = 1'b0;
        wait_idle("rst_idle");
        check("count_final", frame_count === exp_count(),
              $sformatf("got %0d, required %0d", frame_count, exp_count()));

        for (int n = 0; n < 5000 && !b_done; n++) @(negedge CLK12);
        check("b2b_done", b_done, "got unfinished back-to-back run, required finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
